// File: rtl/cla_pipe_addsub.sv
`default_nettype none
// ============================================================================
// Module   : cla_pipe_addsub
// Desc     : Pipelined carry-lookahead adder/subtractor with valid/ready on
//            both sides. Define CLA_FLAGS_EN to add registered z/n flags.
// Revision : 1.0 - initial release
// ============================================================================
module cla_pipe_addsub #(
  parameter int WIDTH  = 32,
  parameter int BLOCK  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ov
`ifdef CLA_FLAGS_EN
  ,
  output logic             z,
  output logic             n
`endif
);

  localparam int GPS = WIDTH / (BLOCK * STAGES);
  localparam int SW  = GPS * BLOCK;

  // Per-stage source operands: stage 0 reads the ports, later stages read
  // the registers of the stage before them.
  logic [WIDTH-1:0]  src_a [STAGES];
  logic [WIDTH-1:0]  src_b [STAGES];
  logic [WIDTH-1:0]  src_s [STAGES];
  logic [STAGES-1:0] src_c;

  logic [WIDTH-1:0]  nxt_s [STAGES];
  logic [STAGES-1:0] nxt_c;
  logic              nxt_ov;

  logic [WIDTH-1:0]  pa_q  [STAGES];
  logic [WIDTH-1:0]  pb_q  [STAGES];
  logic [WIDTH-1:0]  sum_q [STAGES];
  logic [STAGES-1:0] car_q;
  logic [STAGES-1:0] valid_q;
  logic              ov_q;

  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] ld;

  always_comb begin
    src_a[0] = a;
    src_b[0] = sub ? ~b : b;
    src_c[0] = sub ? ~ci : ci;
    src_s[0] = '0;
    for (int k = 1; k < STAGES; k++) begin
      src_a[k] = pa_q[k-1];
      src_b[k] = pb_q[k-1];
      src_c[k] = car_q[k-1];
      src_s[k] = sum_q[k-1];
    end
  end

  // Stage k resolves bits k*SW .. (k+1)*SW-1: group lookahead across the
  // stage's groups, then bit lookahead inside each group from its group carry.
  always_comb begin
    logic [SW-1:0]  x;
    logic [SW-1:0]  y;
    logic [SW-1:0]  p;
    logic [SW-1:0]  g;
    logic [SW-1:0]  bc;
    logic [GPS-1:0] gp;
    logic [GPS-1:0] gg;
    logic [GPS:0]   gc;
    logic           t;
    x      = '0;
    y      = '0;
    p      = '0;
    g      = '0;
    bc     = '0;
    gp     = '0;
    gg     = '0;
    gc     = '0;
    t      = 1'b0;
    nxt_ov = 1'b0;
    nxt_c  = '0;
    for (int k = 0; k < STAGES; k++) begin
      x = src_a[k][k*SW +: SW];
      y = src_b[k][k*SW +: SW];
      p = x ^ y;
      g = x & y;
      for (int j = 0; j < GPS; j++) begin
        gp[j] = &p[j*BLOCK +: BLOCK];
        gg[j] = 1'b0;
        for (int i = 0; i < BLOCK; i++) begin
          t = g[j*BLOCK+i];
          for (int m = i + 1; m < BLOCK; m++) t = t & p[j*BLOCK+m];
          gg[j] = gg[j] | t;
        end
      end
      gc[0] = src_c[k];
      for (int j = 0; j < GPS; j++) begin
        t = src_c[k];
        for (int m = 0; m <= j; m++) t = t & gp[m];
        gc[j+1] = t;
        for (int i = 0; i <= j; i++) begin
          t = gg[i];
          for (int m = i + 1; m <= j; m++) t = t & gp[m];
          gc[j+1] = gc[j+1] | t;
        end
      end
      for (int j = 0; j < GPS; j++) begin
        for (int i = 0; i < BLOCK; i++) begin
          t = gc[j];
          for (int m = 0; m < i; m++) t = t & p[j*BLOCK+m];
          bc[j*BLOCK+i] = t;
          for (int l = 0; l < i; l++) begin
            t = g[j*BLOCK+l];
            for (int m = l + 1; m < i; m++) t = t & p[j*BLOCK+m];
            bc[j*BLOCK+i] = bc[j*BLOCK+i] | t;
          end
        end
      end
      nxt_s[k]              = src_s[k];
      nxt_s[k][k*SW +: SW]  = p ^ bc;
      nxt_c[k]              = gc[GPS];
      // Only the final stage's value survives: carry into MSB vs carry out.
      nxt_ov                = bc[SW-1] ^ gc[GPS];
    end
  end

  always_comb begin
    logic free;
    free = out_ready;
    adv  = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      adv[k] = valid_q[k] & free;
      free   = ~valid_q[k] | adv[k];
    end
  end

  assign in_ready = ~valid_q[0] | adv[0];

  always_comb begin
    ld    = '0;
    ld[0] = in_valid & in_ready;
    for (int k = 1; k < STAGES; k++) ld[k] = adv[k-1];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q <= '0;
      car_q   <= '0;
      ov_q    <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        pa_q[k]  <= '0;
        pb_q[k]  <= '0;
        sum_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (ld[k]) begin
          valid_q[k] <= 1'b1;
          pa_q[k]    <= src_a[k];
          pb_q[k]    <= src_b[k];
          sum_q[k]   <= nxt_s[k];
          car_q[k]   <= nxt_c[k];
        end else if (adv[k]) begin
          valid_q[k] <= 1'b0;
        end
      end
      if (ld[STAGES-1]) ov_q <= nxt_ov;
    end
  end

`ifdef CLA_FLAGS_EN
  logic z_q;
  logic n_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      z_q <= 1'b0;
      n_q <= 1'b0;
    end else if (ld[STAGES-1]) begin
      z_q <= (nxt_s[STAGES-1] == '0);
      n_q <= nxt_s[STAGES-1][WIDTH-1];
    end
  end

  assign z = z_q;
  assign n = n_q;
`endif

  assign out_valid = valid_q[STAGES-1];
  assign s         = sum_q[STAGES-1];
  assign co        = car_q[STAGES-1];
  assign ov        = ov_q;

endmodule
`default_nettype wire

// File: tb/tb_cla_pipe_addsub.sv
`default_nettype none
// tb_cla_pipe_addsub: directed and random beats checked against an
// arithmetic reference model with an in-flight queue.
module tb_cla_pipe_addsub;

  localparam int W   = 16;
  localparam int BLK = 4;
  localparam int STG = 2;
  localparam longint MAXS = (longint'(1) << (W - 1)) - 1;
  localparam longint MINS = -(longint'(1) << (W - 1));

  logic         clk       = 1'b0;
  logic         reset_n   = 1'b0;
  logic         in_valid  = 1'b0;
  logic         in_ready;
  logic [W-1:0] a         = '0;
  logic [W-1:0] b         = '0;
  logic         ci        = 1'b0;
  logic         sub       = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] s;
  logic         co;
  logic         ov;
`ifdef CLA_FLAGS_EN
  logic         z_flag;
  logic         n_flag;
`endif

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } res_t;

  res_t         q[$];
  res_t         exp_r;
  logic         stalled   = 1'b0;
  logic [W-1:0] held_s    = '0;
  logic         held_co   = 1'b0;
  int           saw_block = 0;
  logic         done      = 1'b0;

  always #5 clk = ~clk;

  cla_pipe_addsub #(.WIDTH(W), .BLOCK(BLK), .STAGES(STG)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .ci        (ci),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .co        (co),
    .ov        (ov)
`ifdef CLA_FLAGS_EN
    ,
    .z         (z_flag),
    .n         (n_flag)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic res_t model(input logic [W-1:0] ta, input logic [W-1:0] tbv,
                                 input logic tci, input logic tsub);
    longint ua, ub, sa, sb, ur, sr;
    res_t   r;
    ua = longint'(ta);
    ub = longint'(tbv);
    sa = longint'($signed(ta));
    sb = longint'($signed(tbv));
    if (!tsub) begin
      ur   = ua + ub + longint'(tci);
      sr   = sa + sb + longint'(tci);
      r.co = (ur >= (longint'(1) << W));
    end else begin
      ur   = ua - ub - longint'(tci);
      sr   = sa - sb - longint'(tci);
      r.co = (ur >= 0);
    end
    r.s  = ur[W-1:0];
    r.ov = (sr > MAXS) || (sr < MINS);
    return r;
  endfunction

  // Scoreboard: occupancy, ordering, stall stability and result values.
  always @(negedge clk) begin
    if (!reset_n) begin
      q.delete();
      stalled = 1'b0;
    end else begin
      check("in_ready", 64'(in_ready), 64'((q.size() < STG) || out_ready));
      if (in_valid && !in_ready) saw_block = 1;
      if (q.size() == 0) check("idle_out_valid", 64'(out_valid), 64'd0);
      if (stalled) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_s", 64'(s), 64'(held_s));
        check("hold_co", 64'(co), 64'(held_co));
      end
      if (out_valid && out_ready && q.size() != 0) begin
        exp_r = q.pop_front();
        check("s", 64'(s), 64'(exp_r.s));
        check("co", 64'(co), 64'(exp_r.co));
        check("ov", 64'(ov), 64'(exp_r.ov));
`ifdef CLA_FLAGS_EN
        check("z", 64'(z_flag), 64'(exp_r.s == '0));
        check("n", 64'(n_flag), 64'(exp_r.s[W-1]));
`endif
      end
      stalled = out_valid && !out_ready;
      held_s  = s;
      held_co = co;
      if (in_valid && in_ready) q.push_back(model(a, b, ci, sub));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tbv,
                      input logic tci, input logic tsub);
    int waits;
    waits    = 0;
    a        = ta;
    b        = tbv;
    ci       = tci;
    sub      = tsub;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waits < 100) begin
      @(negedge clk);
      waits++;
    end
    if (!in_ready) check("accept_timeout", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    a        = W'($urandom);
    b        = W'($urandom);
    ci       = 1'($urandom);
    sub      = 1'($urandom);
  endtask

  task automatic run_one(input logic [W-1:0] ta, input logic [W-1:0] tbv,
                         input logic tci, input logic tsub,
                         input logic [W-1:0] es, input logic eco, input logic eov);
    int lat;
    lat       = 0;
    out_ready = 1'b1;
    send(ta, tbv, tci, tsub);
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 50);
    check("latency", 64'(lat), 64'(STG));
    check("dir_s", 64'(s), 64'(es));
    check("dir_co", 64'(co), 64'(eco));
    check("dir_ov", 64'(ov), 64'(eov));
`ifdef CLA_FLAGS_EN
    check("dir_z", 64'(z_flag), 64'(es == '0));
    check("dir_n", 64'(n_flag), 64'(es[W-1]));
`endif
    tick();
  endtask

  task automatic drain();
    int waits;
    waits     = 0;
    out_ready = 1'b1;
    while (q.size() != 0 && waits < 200) begin
      tick();
      waits++;
    end
    check("drain_empty", 64'(q.size()), 64'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  initial begin
    repeat (3) tick();
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_s", 64'(s), 64'd0);
    check("rst_co", 64'(co), 64'd0);
    check("rst_ov", 64'(ov), 64'd0);
    tick();
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    tick();

    run_one(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_one(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_one(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_one(16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0);
    run_one(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    run_one(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0);

    // Six back-to-back beats with the sink stalled in cycles 2..5.
    saw_block = 0;
    fork
      begin
        for (int i = 0; i < 6; i++) send(W'($urandom), W'($urandom), 1'($urandom), 1'b0);
      end
      begin
        out_ready = 1'b1;
        tick();
        tick();
        out_ready = 1'b0;
        repeat (4) tick();
        out_ready = 1'b1;
      end
    join
    drain();
    check("stall_in_ready_low", 64'(saw_block), 64'd1);

    // Reset with two beats held in the pipeline.
    out_ready = 1'b0;
    send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
    send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_s", 64'(s), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    tick();
    out_ready = 1'b1;
    repeat (5) tick();

    // Random traffic with random gaps and random back-pressure.
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
          if ($urandom_range(0, 3) == 0) tick();
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          tick();
        end
        out_ready = 1'b1;
      end
    join
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
